// File: rtl/morse_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : morse_key_decoder
// Description : Single-key Morse decoder. Debounces the key, classifies marks
//               as dot/dash and gaps as letter/word boundaries, looks each
//               letter up in the International Morse table and presents it as
//               a held 8-bit code plus a delayed strobe for the matrix renderer.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_key_decoder #(
  parameter int UNIT_CYCLES     = 2500000,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STROBE_CYCLES   = 4
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       KEY,
  output logic [7:0] LETTER,
  output logic       STROBE,
  output logic       BUSY
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PC_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PC_W-1:0] PC_LAST   = PC_W'(STROBE_CYCLES - 1);
  localparam logic [25:0]     DASH_TH   = 26'(2 * UNIT_CYCLES);
  localparam logic [25:0]     LETTER_TH = 26'(3 * UNIT_CYCLES);
  localparam logic [25:0]     WORD_TH   = 26'(7 * UNIT_CYCLES);
  localparam logic [7:0]      CODE_WORD = 8'd29;
  localparam logic [7:0]      CODE_BAD  = 8'd30;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MARK     = 3'd1,
    GAP      = 3'd2,
    EMIT     = 3'd3,
    PULSE    = 3'd4,
    WORDWAIT = 3'd5
  } state_t;

  state_t          state, next_state;
  logic            sync1, sync2, kd, kd_d;
  logic [DB_W-1:0] db_cnt;
  logic [25:0]     mark_cnt, gap_cnt;
  logic [4:0]      el_buf;
  logic [2:0]      el_cnt;
  logic            ovf, sel_word;
  logic [PC_W-1:0] pulse_cnt;
  logic            kd_rise, kd_fall;
  logic            append, emit, set_sel, sel_word_in;

  assign kd_rise = kd & ~kd_d;
  assign kd_fall = ~kd & kd_d;
  assign BUSY    = (state != IDLE) && (state != WORDWAIT);

  // Letter table: elements in order, dot=0 dash=1, newest in the LSB.
  function automatic logic [7:0] lookup(input logic [2:0] n, input logic [4:0] b);
    logic [7:0] code;
    code = CODE_BAD;
    case ({n, b})
      {3'd2, 5'b00001}: code = 8'd1;   // A .-
      {3'd4, 5'b01000}: code = 8'd2;   // B -...
      {3'd4, 5'b01010}: code = 8'd3;   // C -.-.
      {3'd3, 5'b00100}: code = 8'd4;   // D -..
      {3'd1, 5'b00000}: code = 8'd5;   // E .
      {3'd4, 5'b00010}: code = 8'd6;   // F ..-.
      {3'd3, 5'b00110}: code = 8'd7;   // G --.
      {3'd4, 5'b00000}: code = 8'd8;   // H ....
      {3'd2, 5'b00000}: code = 8'd9;   // I ..
      {3'd4, 5'b00111}: code = 8'd10;  // J .---
      {3'd3, 5'b00101}: code = 8'd11;  // K -.-
      {3'd4, 5'b00100}: code = 8'd12;  // L .-..
      {3'd2, 5'b00011}: code = 8'd13;  // M --
      {3'd2, 5'b00010}: code = 8'd14;  // N -.
      {3'd3, 5'b00111}: code = 8'd15;  // O ---
      {3'd4, 5'b00110}: code = 8'd16;  // P .--.
      {3'd4, 5'b01101}: code = 8'd17;  // Q --.-
      {3'd3, 5'b00010}: code = 8'd18;  // R .-.
      {3'd3, 5'b00000}: code = 8'd19;  // S ...
      {3'd1, 5'b00001}: code = 8'd20;  // T -
      {3'd3, 5'b00001}: code = 8'd21;  // U ..-
      {3'd4, 5'b00001}: code = 8'd22;  // V ...-
      {3'd3, 5'b00011}: code = 8'd23;  // W .--
      {3'd4, 5'b01001}: code = 8'd24;  // X -..-
      {3'd4, 5'b01011}: code = 8'd25;  // Y -.--
      {3'd4, 5'b01100}: code = 8'd26;  // Z --..
      default:          code = CODE_BAD;
    endcase
    return code;
  endfunction

  // Two-flop synchroniser followed by a consecutive-disagreement debouncer.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      kd     <= 1'b0;
      kd_d   <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
      kd_d  <= kd;
      if (sync2 == kd) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        kd     <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Saturating mark/gap length counters; the edge cycle is the first counted cycle.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      mark_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      if (kd_rise)                    mark_cnt <= 26'd1;
      else if (kd && mark_cnt != '1)  mark_cnt <= mark_cnt + 26'd1;
      if (kd_fall)                    gap_cnt  <= 26'd1;
      else if (!kd && gap_cnt != '1)  gap_cnt  <= gap_cnt + 26'd1;
    end
  end

  // State register.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and datapath control; a gap threshold wins over a same-cycle key rise.
  always_comb begin
    next_state  = state;
    append      = 1'b0;
    emit        = 1'b0;
    set_sel     = 1'b0;
    sel_word_in = 1'b0;
    case (state)
      IDLE: if (kd_rise) next_state = MARK;
      MARK: begin
        if (kd_fall) begin
          append     = 1'b1;
          next_state = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == LETTER_TH) begin
          set_sel    = 1'b1;
          next_state = EMIT;
        end else if (kd_rise) begin
          next_state = MARK;
        end
      end
      EMIT: begin
        emit       = 1'b1;
        next_state = PULSE;
      end
      PULSE: begin
        if (pulse_cnt == PC_LAST) begin
          if (kd)             next_state = MARK;
          else if (!sel_word) next_state = WORDWAIT;
          else                next_state = IDLE;
        end
      end
      WORDWAIT: begin
        if (gap_cnt == WORD_TH) begin
          set_sel     = 1'b1;
          sel_word_in = 1'b1;
          next_state  = EMIT;
        end else if (kd_rise) begin
          next_state = MARK;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Element buffer, code register and strobe; STROBE lags PULSE by one cycle for setup.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      el_buf    <= '0;
      el_cnt    <= '0;
      ovf       <= 1'b0;
      sel_word  <= 1'b0;
      LETTER    <= '0;
      pulse_cnt <= '0;
      STROBE    <= 1'b0;
    end else begin
      if (append) begin
        if (el_cnt == 3'd5) begin
          ovf <= 1'b1;
        end else begin
          el_buf <= {el_buf[3:0], (mark_cnt >= DASH_TH)};
          el_cnt <= el_cnt + 3'd1;
        end
      end
      if (set_sel) sel_word <= sel_word_in;
      if (emit) begin
        if (sel_word) LETTER <= CODE_WORD;
        else if (ovf) LETTER <= CODE_BAD;
        else          LETTER <= lookup(el_cnt, el_buf);
        el_buf <= '0;
        el_cnt <= '0;
        ovf    <= 1'b0;
      end
      pulse_cnt <= (state == PULSE) ? pulse_cnt + 1'b1 : '0;
      STROBE    <= (state == PULSE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_morse_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_key_decoder
// Description : Directed self-checking bench for morse_key_decoder with
//               UNIT=10, DEBOUNCE=4, STROBE=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_key_decoder;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       KEY   = 1'b0;
  logic [7:0] LETTER;
  logic       STROBE;
  logic       BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations gathered by the monitor.
  int         cyc        = 0;
  int         n_rises    = 0;
  int         last_code  = -1;
  int         last_delta = -1;
  int         last_len   = -1;
  int         t_letter   = 0;
  int         t_rise     = 0;
  int         viol       = 0;
  logic       busy_seen  = 1'b0;
  logic [7:0] prev_letter = 8'd0;
  logic       prev_strobe = 1'b0;

  int exp_rises = 0;
  int r0;
  logic found;

  morse_key_decoder #(
    .UNIT_CYCLES    (10),
    .DEBOUNCE_CYCLES(4),
    .STROBE_CYCLES  (3)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .KEY   (KEY),
    .LETTER(LETTER),
    .STROBE(STROBE),
    .BUSY  (BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  // Track strobe rises, their setup after LETTER changes, pulse length and LETTER stability.
  always @(negedge CLOCK) begin
    cyc++;
    if (BUSY === 1'b1) busy_seen = 1'b1;
    if (LETTER !== prev_letter) begin
      if (prev_strobe && STROBE) viol++;
      t_letter = cyc;
    end
    if (STROBE && !prev_strobe) begin
      n_rises++;
      last_code  = int'(LETTER);
      last_delta = cyc - t_letter;
      t_rise     = cyc;
    end
    if (!STROBE && prev_strobe) last_len = cyc - t_rise;
    prev_letter = LETTER;
    prev_strobe = STROBE;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic hold(input logic level, input int n);
    KEY = level;
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  // Key one letter: '.' is a 10-cycle mark, '-' a 30-cycle mark, 10-cycle gaps, 50 of silence after.
  task automatic key_letter(input string pat);
    for (int i = 0; i < pat.len(); i++) begin
      hold(1'b1, (pat[i] == 8'h2d) ? 30 : 10);
      if (i != pat.len() - 1) hold(1'b0, 10);
    end
    hold(1'b0, 50);
  endtask

  task automatic expect_letter(input string tag, input int code);
    exp_rises++;
    check({tag, "_rises"}, n_rises, exp_rises);
    check({tag, "_code"}, last_code, code);
    check({tag, "_letter"}, LETTER, code);
  endtask

  task automatic flush_word();
    hold(1'b0, 120);
    exp_rises++;
    check("word_rises", n_rises, exp_rises);
    check("word_code", last_code, 29);
  endtask

  initial begin
    #1 RESET = 1'b1;
    repeat (3) @(posedge CLOCK);
    #1;
    check("rst_letter", LETTER, 0);
    check("rst_strobe", STROBE, 0);
    check("rst_busy", BUSY, 0);
    RESET = 1'b0;
    hold(1'b0, 10);

    // 2-cycle glitches never survive the debouncer.
    busy_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      hold(1'b1, 2);
      hold(1'b0, 2);
    end
    hold(1'b0, 20);
    check("glitch_busy", busy_seen, 0);
    check("glitch_rises", n_rises, 0);
    check("glitch_letter", LETTER, 0);

    // A, then a single word space once silence reaches 70.
    hold(1'b1, 10); hold(1'b0, 10); hold(1'b1, 30); hold(1'b0, 50);
    expect_letter("a", 1);
    check("a_setup", last_delta, 1);
    check("a_len", last_len, 3);
    hold(1'b0, 20);
    check("a_no_early_word", n_rises, 1);
    hold(1'b0, 40);
    exp_rises++;
    check("a_word_rises", n_rises, exp_rises);
    check("a_word_letter", LETTER, 29);
    check("a_word_setup", last_delta, 1);
    check("a_word_len", last_len, 3);
    hold(1'b0, 150);
    check("a_idle_rises", n_rises, exp_rises);
    check("a_idle_busy", BUSY, 0);

    // B, then four dots with a 25-cycle gap before the last stay one letter (H).
    key_letter("-...");
    expect_letter("b", 2);
    hold(1'b1, 10); hold(1'b0, 10); hold(1'b1, 10); hold(1'b0, 10);
    hold(1'b1, 10); hold(1'b0, 25); hold(1'b1, 10); hold(1'b0, 50);
    expect_letter("h", 8);
    flush_word();

    // Overflow and unknown pattern.
    key_letter("......");
    expect_letter("six_dots", 30);
    flush_word();
    key_letter("----");
    expect_letter("four_dash", 30);
    flush_word();

    // Dot/dash boundary: 20 cycles is a dash, 19 a dot.
    hold(1'b1, 20); hold(1'b0, 50);
    expect_letter("mark20", 20);
    flush_word();
    hold(1'b1, 19); hold(1'b0, 50);
    expect_letter("mark19", 5);
    flush_word();

    // Reset during the strobe pulse.
    hold(1'b1, 10);
    KEY   = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge CLOCK);
      #1;
      if (STROBE === 1'b1) found = 1'b1;
    end
    check("pulse_seen", found, 1);
    #1 RESET = 1'b1;
    #1;
    check("rst_pulse_strobe", STROBE, 0);
    check("rst_pulse_letter", LETTER, 0);
    r0 = n_rises;
    @(posedge CLOCK);
    #1 RESET = 1'b0;
    hold(1'b0, 150);
    check("post_rst_rises", n_rises, r0);
    check("post_rst_letter", LETTER, 0);
    hold(1'b1, 10); hold(1'b0, 50);
    check("post_rst_e_rises", n_rises, r0 + 1);
    check("post_rst_e_code", last_code, 5);

    check("letter_stable", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
